// File: rtl/fifo_rd_drain.sv
// Read-side drain controller: pulls words from a synchronous FIFO into a
// 2-entry output buffer and streams them out on valid/ready.
// Optional delivered-word counter is built when FIFO_RD_CNT_EN is defined.
module fifo_rd_drain #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              empty,
   input  logic [DATA_W-1:0] rdata,
   output logic              rd_en,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [CNT_W-1:0]  rd_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        occ_q, occ_d;
   logic              infl_q, infl_d;
   logic [DATA_W-1:0] buf0_q, buf0_d;
   logic [DATA_W-1:0] buf1_q, buf1_d;

   logic              pop;
   logic [2:0]        fill;
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] nxt1;

   // The landing word is visible in its arrival cycle, so an empty buffer
   // forwards rdata straight to the stream.
   assign head    = (occ_q != 2'd0) ? buf0_q : rdata;
   assign nxt1    = (occ_q == 2'd2) ? buf1_q : rdata;
   assign m_valid = (occ_q != 2'd0) || infl_q;
   assign m_data  = m_valid ? head : '0;
   assign pop     = m_valid && m_ready;
   assign fill    = {1'b0, occ_q} + {2'b00, infl_q};
   assign rd_en   = (state_q == RUN) && !empty
                 && (fill <= ({2'b00, pop} + 3'd1));
   assign busy    = (state_q != IDLE);

   // Next-state for the FSM and the output buffer.
   always_comb begin
      state_d = state_q;
      infl_d  = rd_en;
      occ_d   = occ_q + {1'b0, infl_q} - {1'b0, pop};
      buf0_d  = buf0_q;
      buf1_d  = buf1_q;
      if (infl_q || pop) begin
         buf0_d = pop ? nxt1  : head;
         buf1_d = pop ? rdata : nxt1;
      end
      unique case (state_q)
         IDLE: begin
            if (enable) state_d = RUN;
         end
         RUN: begin
            if (!enable) state_d = DRAIN;
         end
         DRAIN: begin
            if (enable) state_d = RUN;
            else if (occ_q == 2'd0 && !infl_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, occupancy and buffer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         occ_q   <= 2'd0;
         infl_q  <= 1'b0;
         buf0_q  <= '0;
         buf1_q  <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         infl_q  <= infl_d;
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
      end
   end

`ifdef FIFO_RD_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, pop};
   assign rd_cnt = cnt_q;

   // Delivered-word counter, wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
`else
   logic unused_cfg;
   assign unused_cfg = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: emulates the FIFO and compares every cycle
// against a queue-based model of words read versus words delivered.
module tb_fifo_rd_drain;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       empty;
   logic [7:0] rdata;
   logic       rd_en;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       busy;
`ifdef FIFO_RD_CNT_EN
   logic [3:0] rd_cnt;
`endif

   fifo_rd_drain #(
      .DATA_W(8),
      .CNT_W (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .empty  (empty),
      .rdata  (rdata),
      .rd_en  (rd_en),
      .m_data (m_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .busy   (busy)
`ifdef FIFO_RD_CNT_EN
      ,
      .rd_cnt (rd_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] fq[$];
   logic [7:0] mq[$];
   logic [7:0] pend[$];
   bit         run_m, busy_m;
   int         cnt_m;
   int         n_chk, n_fail;
   bit         rd_s, val_s, busy_s, emp_s, rdy_s;
   logic [7:0] dat_s;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] w);
      fq.push_back(w);
      mq.push_back(w);
      empty = 1'b0;
   endtask

   task automatic model_reset();
      fq.delete();
      mq.delete();
      pend.delete();
      run_m  = 0;
      busy_m = 0;
      cnt_m  = 0;
   endtask

   task automatic step();
      int depth;
      bit pop_e, rd_e;
      @(negedge clk);
      depth = pend.size();
      pop_e = (depth != 0) && m_ready;
      rd_e  = rst && run_m && !empty && ((depth - int'(pop_e)) <= 1);
      rd_s   = rd_en;
      val_s  = m_valid;
      dat_s  = m_data;
      busy_s = busy;
      emp_s  = empty;
      rdy_s  = m_ready;
      chk("rd_en", 32'(rd_en), 32'(rd_e));
      chk("m_valid", 32'(m_valid), 32'(depth != 0));
      if (depth != 0) chk("m_data", 32'(m_data), 32'(pend[0]));
      chk("busy", 32'(busy), 32'(busy_m));
`ifdef FIFO_RD_CNT_EN
      chk("rd_cnt", 32'(rd_cnt), 32'(cnt_m % 16));
`endif
      @(posedge clk);
      if (!rst) begin
         model_reset();
      end else begin
         if (pop_e) begin
            void'(pend.pop_front());
            cnt_m++;
         end
         if (rd_e && mq.size() > 0) pend.push_back(mq.pop_front());
         if (enable) begin
            run_m  = 1;
            busy_m = 1;
         end else if (run_m) begin
            run_m = 0;
         end else if (busy_m && depth == 0) begin
            busy_m = 0;
         end
      end
      #1;
      if (rst && rd_s && fq.size() > 0) rdata = fq.pop_front();
      empty = (fq.size() == 0);
   endtask

   initial begin
      logic [7:0] fw[3];
      logic [7:0] bp[8];
      int nrd, nv, rde, ndl;
      fw = '{8'h11, 8'h22, 8'h33};
      n_chk  = 0;
      n_fail = 0;
      model_reset();
      rst     = 1'b0;
      enable  = 1'b0;
      empty   = 1'b1;
      m_ready = 1'b0;
      rdata   = '0;

      // reset held with random inputs
      for (int i = 0; i < 5; i++) begin
         enable  = 1'($urandom);
         m_ready = 1'($urandom);
         rdata   = 8'($urandom);
         empty   = 1'($urandom);
         #1;
         step();
         chk("rst_m_data", 32'(dat_s), 32'(0));
         chk("rst_rd_en", 32'(rd_s), 32'(0));
      end
      enable = 1'b0;
      rst = 1'b1;
      step();

      // first three words on cycles 2..4
      for (int i = 0; i < 3; i++) push(fw[i]);
      enable  = 1'b1;
      m_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         step();
         if (k >= 2 && k <= 4)
            chk("first_words", {23'd0, val_s, dat_s}, {23'd0, 1'b1, fw[k-2]});
         if (k == 5) chk("first_done", 32'(val_s), 32'(0));
      end

      // back-pressure: two reads then hold word 0
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bp[i] = 8'($urandom);
         push(bp[i]);
      end
      nrd = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         nrd += int'(rd_s);
         if (k >= 2) chk("bp_hold", {23'd0, val_s, dat_s}, {23'd0, 1'b1, bp[0]});
      end
      chk("bp_reads", 32'(nrd), 32'(2));
      m_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("bp_order", {23'd0, val_s, dat_s}, {23'd0, 1'b1, bp[k]});
      end

      // single word boundary
      step();
      push(8'hA5);
      nrd = 0;
      nv  = 0;
      rde = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         nrd += int'(rd_s);
         nv  += int'(val_s);
         rde += int'(rd_s && emp_s);
      end
      chk("one_read", 32'(nrd), 32'(1));
      chk("one_valid", 32'(nv), 32'(1));
      chk("rd_while_empty", 32'(rde), 32'(0));
      chk("one_valid_end", 32'(val_s), 32'(0));

      // drain with a full buffer and one more read
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
      for (int k = 0; k < 4; k++) step();
      enable  = 1'b0;
      m_ready = 1'b1;
      step();
      chk("drain_last_rd", 32'(rd_s), 32'(1));
      ndl = int'(val_s);
      nrd = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         nrd += int'(rd_s);
         ndl += int'(val_s && rdy_s);
      end
      chk("drain_no_rd", 32'(nrd), 32'(0));
      chk("drain_words", 32'(ndl), 32'(3));
      chk("drain_idle", 32'(busy_s), 32'(0));

      // asynchronous reset with a full buffer
      enable  = 1'b1;
      m_ready = 1'b0;
      for (int k = 0; k < 4; k++) step();
      #2;
      rst = 1'b0;
      #1;
      chk("async_m_valid", 32'(m_valid), 32'(0));
      chk("async_busy", 32'(busy), 32'(0));
      model_reset();
      empty = 1'b1;
      for (int k = 0; k < 2; k++) begin
         m_ready = 1'($urandom);
         step();
      end
      rst     = 1'b1;
      m_ready = 1'b1;
      nv = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         nv += int'(val_s);
      end
      chk("no_stale", 32'(nv), 32'(0));

      // 17 deliveries after reset
      for (int i = 0; i < 17; i++) push(8'($urandom));
      ndl = 0;
      for (int k = 0; k < 22; k++) begin
         step();
         ndl += int'(val_s && rdy_s);
      end
      chk("cnt_words", 32'(ndl), 32'(17));
`ifdef FIFO_RD_CNT_EN
      chk("rd_cnt_wrap", 32'(rd_cnt), 32'(1));
`endif

      // random traffic
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 2) == 0 && fq.size() < 12) push(8'($urandom));
         m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) enable = ~enable;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
